param_deinterleaver: RTL and testbench



---
 rtl/param_deinterleaver.sv | 172 +++++++++++++++++
 tb/tb_param_deinterleaver.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/param_deinterleaver.sv
// Ping-pong block deinterleaver: one RAM bank fills while the other drains in
// column-major (deinterleave) or linear (bypass) order, split into gapped subframes.
module param_deinterleaver #(
  parameter int unsigned DW   = 5,
  parameter int unsigned ROWS = 64,
  parameter int unsigned COLS = 72,
  parameter int unsigned NSUB = 2,
  parameter int unsigned GAP  = 1000
) (
  input  logic          iclk,
  input  logic          irst,
  input  logic          isop,
  input  logic          ival,
  input  logic [DW-1:0] idat,
  input  logic          imode,
  input  logic          iready,
  output logic          osop,
  output logic          oeop,
  output logic          oeof,
  output logic          oval,
  output logic [DW-1:0] odat,
  output logic          oerr
);
  localparam int unsigned N   = ROWS * COLS;
  localparam int unsigned SUB = N / NSUB;
  localparam int unsigned AW  = $clog2(N);
  localparam int unsigned GW  = (GAP > 0) ? $clog2(GAP + 1) : 1;

  localparam logic [AW-1:0] LastIdx = AW'(N - 1);
  localparam logic [AW-1:0] LastSub = AW'(SUB - 1);
  localparam logic [AW-1:0] LastRow = AW'(ROWS - 1);
  localparam logic [AW-1:0] ColStep = AW'(COLS);
  localparam logic [GW-1:0] LastGap = GW'(GAP - 1);

  typedef enum logic [1:0] {StIdle, StRead, StGap} state_e;

  state_e        state_q;
  logic          open_q, mode_q, wbank_q, rbank_q, rmode_q;
  logic [AW-1:0] k_q, waddr;
  logic          we, done, read_free, swap;
  logic [AW-1:0] j_q, s_q, r_q, c_q, a_q, raddr_q;
  logic [GW-1:0] g_q;
  logic          s1_bank_q, s1_val, s1_sop, s1_eop, s1_eof;
  logic          s2_val, s2_sop, s2_eop, s2_eof;
  logic [DW-1:0] rdat_q;
  logic [DW-1:0] mem0 [N];
  logic [DW-1:0] mem1 [N];

  assign we        = ival & (isop | open_q);
  assign waddr     = isop ? '0 : k_q;
  assign done      = we & (waddr == LastIdx);
  // The reader releasing its bank on this very edge still counts as free.
  assign read_free = (state_q == StIdle) | ((state_q == StRead) & iready & (j_q == LastIdx));
  assign swap      = done & read_free;

  always_ff @(posedge iclk or negedge irst) begin
    if (!irst) begin
      open_q  <= 1'b0;
      k_q     <= '0;
      mode_q  <= 1'b0;
      wbank_q <= 1'b0;
      oerr    <= 1'b0;
    end else begin
      if (we) begin
        open_q <= ~done;
        k_q    <= done ? '0 : waddr + AW'(1);
        if (isop) mode_q <= imode;
      end
      if (swap) begin
        wbank_q <= ~wbank_q;
        oerr    <= 1'b0;
      end else if (done) begin
        oerr <= 1'b1;
      end
    end
  end

  // Bank id travels with the address so a swap cannot redirect an in-flight read.
  always_ff @(posedge iclk) begin
    if (we && !wbank_q) mem0[waddr] <= idat;
    if (we &&  wbank_q) mem1[waddr] <= idat;
    if (iready) rdat_q <= s1_bank_q ? mem1[raddr_q] : mem0[raddr_q];
  end

  always_ff @(posedge iclk or negedge irst) begin
    if (!irst) begin
      state_q   <= StIdle;
      rbank_q   <= 1'b0;
      rmode_q   <= 1'b0;
      j_q       <= '0;
      s_q       <= '0;
      r_q       <= '0;
      c_q       <= '0;
      a_q       <= '0;
      g_q       <= '0;
      raddr_q   <= '0;
      s1_bank_q <= 1'b0;
      s1_val    <= 1'b0;
      s1_sop    <= 1'b0;
      s1_eop    <= 1'b0;
      s1_eof    <= 1'b0;
      s2_val    <= 1'b0;
      s2_sop    <= 1'b0;
      s2_eop    <= 1'b0;
      s2_eof    <= 1'b0;
      oval      <= 1'b0;
      osop      <= 1'b0;
      oeop      <= 1'b0;
      oeof      <= 1'b0;
      odat      <= '0;
    end else begin
      if (iready) begin
        s1_val <= 1'b0;
        s1_sop <= 1'b0;
        s1_eop <= 1'b0;
        s1_eof <= 1'b0;
        unique case (state_q)
          StRead: begin
            raddr_q   <= rmode_q ? j_q : a_q;
            s1_bank_q <= rbank_q;
            s1_val    <= 1'b1;
            s1_sop    <= (s_q == '0);
            s1_eop    <= (s_q == LastSub);
            s1_eof    <= (j_q == LastIdx);
            j_q       <= j_q + AW'(1);
            s_q       <= (s_q == LastSub) ? '0 : s_q + AW'(1);
            // Column-major walk: step by COLS down a column, then move to the next column.
            if (r_q == LastRow) begin
              r_q <= '0;
              c_q <= c_q + AW'(1);
              a_q <= c_q + AW'(1);
            end else begin
              r_q <= r_q + AW'(1);
              a_q <= a_q + ColStep;
            end
            if (j_q == LastIdx) begin
              state_q <= StIdle;
            end else if ((s_q == LastSub) && (GAP > 0)) begin
              state_q <= StGap;
              g_q     <= '0;
            end
          end
          StGap: begin
            if (g_q == LastGap) state_q <= StRead;
            else                g_q     <= g_q + GW'(1);
          end
          default: ;
        endcase
        s2_val <= s1_val;
        s2_sop <= s1_sop;
        s2_eop <= s1_eop;
        s2_eof <= s1_eof;
        oval   <= s2_val;
        osop   <= s2_sop;
        oeop   <= s2_eop;
        oeof   <= s2_eof;
        odat   <= s2_val ? rdat_q : '0;
      end
      if (swap) begin
        state_q <= StRead;
        rbank_q <= wbank_q;
        rmode_q <= mode_q;
        j_q     <= '0;
        s_q     <= '0;
        r_q     <= '0;
        c_q     <= '0;
        a_q     <= '0;
      end
    end
  end

endmodule

// File: tb/tb_param_deinterleaver.sv
// Directed bench for param_deinterleaver at default parameters: ordering, framing,
// latency, back-pressure, overflow, packet restart and mid-read reset.
module tb_param_deinterleaver;
  localparam int DW   = 5;
  localparam int ROWS = 64;
  localparam int COLS = 72;
  localparam int N    = ROWS * COLS;
  localparam int SUB  = N / 2;

  typedef struct {
    logic [DW-1:0] dat;
    logic          sop, eop, eof;
    int            cyc;
  } beat_t;

  logic          iclk = 1'b0;
  logic          irst = 1'b0;
  logic          isop = 1'b0, ival = 1'b0, imode = 1'b0, iready = 1'b1;
  logic [DW-1:0] idat = '0;
  logic          osop, oeop, oeof, oval, oerr;
  logic [DW-1:0] odat;

  int    tests = 0, fails = 0;
  int    cyc = 0, last_wr = 0, base = 0;
  int    stall_chks = 0, stall_errs = 0;
  logic  stall_chk = 1'b0;
  logic  p_stall = 1'b0;
  logic [DW+3:0] p_vec = '0;
  beat_t q[$];

  param_deinterleaver dut (
    .iclk(iclk), .irst(irst), .isop(isop), .ival(ival), .idat(idat), .imode(imode),
    .iready(iready), .osop(osop), .oeop(oeop), .oeof(oeof), .oval(oval), .odat(odat),
    .oerr(oerr)
  );

  always #5 iclk = ~iclk;
  always @(posedge iclk) cyc <= cyc + 1;

  // Capture every accepted beat; while stalled, the held beat must not change.
  always @(negedge iclk) begin
    if (oval && iready) q.push_back('{odat, osop, oeop, oeof, cyc});
    if (stall_chk && p_stall) begin
      stall_chks <= stall_chks + 1;
      if ({oval, osop, oeop, oeof, odat} !== p_vec) stall_errs <= stall_errs + 1;
    end
    p_stall <= oval && !iready;
    p_vec   <= {oval, osop, oeop, oeof, odat};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input bit md, input int off, input int n);
    for (int k = 0; k < n; k++) begin
      isop  = (k == 0);
      ival  = 1'b1;
      imode = md;
      idat  = DW'((k + off) % 32);
      @(posedge iclk); #1;
    end
    isop = 1'b0; ival = 1'b0;
    last_wr = cyc;
  endtask

  task automatic wait_beats(input string tag, input int target, input int budget);
    int n = 0;
    while (q.size() < target && n < budget) begin
      @(posedge iclk); #1;
      n++;
    end
    chk({tag, "_arrived"}, 32'(q.size() >= target), 32'd1);
  endtask

  task automatic check_pkt(input string tag, input int b, input bit md, input int off);
    int derr = 0, ferr = 0, a, e;
    chk({tag, "_len"}, 32'(q.size() - b), 32'(N));
    for (int j = 0; j < N; j++) begin
      if (b + j < q.size()) begin
        a = md ? j : (j % ROWS) * COLS + j / ROWS;
        e = (a + off) % 32;
        if (q[b + j].dat !== DW'(e)) derr++;
        if (q[b + j].sop !== (j % SUB == 0))       ferr++;
        if (q[b + j].eop !== (j % SUB == SUB - 1)) ferr++;
        if (q[b + j].eof !== (j == N - 1))         ferr++;
      end
    end
    chk({tag, "_data_errs"}, 32'(derr), 32'd0);
    chk({tag, "_flag_errs"}, 32'(ferr), 32'd0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge iclk);
    #1;
    chk("rst_oval", 32'(oval), 0);
    chk("rst_osop", 32'(osop), 0);
    chk("rst_oeop", 32'(oeop), 0);
    chk("rst_oeof", 32'(oeof), 0);
    chk("rst_oerr", 32'(oerr), 0);
    chk("rst_odat", 32'(odat), 0);
    irst = 1'b1;
    repeat (3) @(posedge iclk);
    #1;

    // Deinterleave, iready high: order, latency, burst/gap shape
    base = q.size();
    send(1'b0, 0, N);
    wait_beats("deint", base + N, N + 2000);
    chk("deint_j0", 32'(q[base].dat), 0);
    chk("deint_j1", 32'(q[base + 1].dat), 8);
    chk("deint_j2", 32'(q[base + 2].dat), 16);
    chk("deint_j3", 32'(q[base + 3].dat), 24);
    chk("deint_j4", 32'(q[base + 4].dat), 0);
    chk("deint_latency", 32'(q[base].cyc - last_wr), 3);
    chk("deint_burst0", 32'(q[base + SUB - 1].cyc - q[base].cyc), SUB - 1);
    chk("deint_gap", 32'(q[base + SUB].cyc - q[base + SUB - 1].cyc), 1001);
    chk("deint_burst1", 32'(q[base + N - 1].cyc - q[base + SUB].cyc), SUB - 1);
    check_pkt("deint", base, 1'b0, 0);
    chk("deint_oerr", 32'(oerr), 0);
    repeat (2) @(posedge iclk);
    #1;
    chk("deint_idle_oval", 32'(oval), 0);

    // Bypass
    base = q.size();
    send(1'b1, 0, N);
    wait_beats("bypass", base + N, N + 2000);
    check_pkt("bypass", base, 1'b1, 0);

    // Overflow: second packet lands while the first is still draining
    base = q.size();
    send(1'b0, 0, N);
    send(1'b0, 7, N);
    chk("ovf_oerr_set", 32'(oerr), 1);
    wait_beats("ovf_first", base + N, N + 2000);
    check_pkt("ovf_first", base, 1'b0, 0);
    repeat (3) @(posedge iclk);
    #1;
    base = q.size();
    send(1'b0, 3, N);
    chk("ovf_oerr_clear", 32'(oerr), 0);
    wait_beats("ovf_third", base + N, N + 2000);
    check_pkt("ovf_third", base, 1'b0, 3);

    // Random back-pressure
    base = q.size();
    send(1'b0, 0, N);
    stall_chk = 1'b1;
    for (int n = 0; n < 40000 && q.size() < base + N; n++) begin
      iready = 1'($urandom_range(0, 1));
      @(posedge iclk); #1;
    end
    iready = 1'b1;
    @(posedge iclk); #1;
    stall_chk = 1'b0;
    chk("bp_arrived", 32'(q.size() >= base + N), 1);
    check_pkt("bp", base, 1'b0, 0);
    chk("bp_stall_errs", 32'(stall_errs), 0);
    chk("bp_stalls_seen", 32'(stall_chks > 0), 1);

    // Stray ival with no open packet, then a restart at k=100
    repeat (3) @(posedge iclk);
    #1;
    base = q.size();
    ival = 1'b1; idat = '1;
    repeat (5) @(posedge iclk);
    #1;
    ival = 1'b0;
    send(1'b0, 9, 100);
    send(1'b0, 0, N);
    wait_beats("restart", base + N, N + 2000);
    repeat (20) @(posedge iclk);
    #1;
    check_pkt("restart", base, 1'b0, 0);

    // Reset in the middle of the read
    base = q.size();
    send(1'b0, 0, N);
    wait_beats("rstmid", base + 1000, 2000);
    irst = 1'b0;
    #1;
    chk("rstmid_oval", 32'(oval), 0);
    chk("rstmid_odat", 32'(odat), 0);
    chk("rstmid_flags", 32'({osop, oeop, oeof, oerr}), 0);
    repeat (2) @(posedge iclk);
    #1;
    irst = 1'b1;
    repeat (1500) @(posedge iclk);
    #1;
    chk("rstmid_no_more", 32'(q.size() - base), 1000);
    chk("rstmid_oval_after", 32'(oval), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
